// File: rtl/inst_mem_loadable.sv
// Instruction memory with a one-cycle registered fetch port and a
// valid/ready program-load port controlled by an IDLE/LOAD/DONE state machine.
module inst_mem_loadable #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic                  Stall,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstValid,
  output logic                  AddrFault,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Address bits above the word index must all be zero for a valid fetch.
  localparam logic [31:0] HIGH_MASK = ~((32'h00000001 << (ADDR_WIDTH + 2)) - 32'h00000001);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] instruction_r;
  logic                  inst_valid_r;
  logic                  addr_fault_r;
  logic                  load_ready_r;
  logic                  load_done_r;

  logic [ADDR_WIDTH-1:0] fetch_index_s;
  logic                  fetch_fault_s;
  logic                  write_en_s;
  logic                  ptr_at_end_s;

  // Fetch address decode and load-write qualification.
  always_comb begin
    fetch_index_s = Address[ADDR_WIDTH+1:2];
    fetch_fault_s = (Address[1:0] != 2'b00) || ((Address & HIGH_MASK) != 32'h00000000);
    ptr_at_end_s  = (ptr_r == {ADDR_WIDTH{1'b1}});
    if ((state_r == LOAD) && load_valid && !reset) begin
      write_en_s = 1'b1;
    end else begin
      write_en_s = 1'b0;
    end
  end

  // Program storage: deliberately not reset so a reset never loses a program.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      mem_r[ptr_r] <= load_data;
    end
  end

  // Load state machine and registered fetch outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      ptr_r         <= {ADDR_WIDTH{1'b0}};
      count_r       <= {(ADDR_WIDTH+1){1'b0}};
      instruction_r <= NOP_WORD;
      inst_valid_r  <= 1'b0;
      addr_fault_r  <= 1'b0;
      load_ready_r  <= 1'b0;
      load_done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          load_done_r <= 1'b0;
          if (load_start) begin
            state_r       <= LOAD;
            ptr_r         <= {ADDR_WIDTH{1'b0}};
            count_r       <= {(ADDR_WIDTH+1){1'b0}};
            load_ready_r  <= 1'b1;
            instruction_r <= NOP_WORD;
            inst_valid_r  <= 1'b0;
            addr_fault_r  <= 1'b0;
          end else if (!Stall) begin
            if (fetch_fault_s) begin
              instruction_r <= NOP_WORD;
              inst_valid_r  <= 1'b0;
              addr_fault_r  <= 1'b1;
            end else begin
              instruction_r <= mem_r[fetch_index_s];
              inst_valid_r  <= 1'b1;
              addr_fault_r  <= 1'b0;
            end
          end
        end
        LOAD: begin
          instruction_r <= NOP_WORD;
          inst_valid_r  <= 1'b0;
          addr_fault_r  <= 1'b0;
          if (load_valid) begin
            count_r <= count_r + CNT_ONE;
            // Pointer saturates at the last word; the transition to DONE stops writes.
            if (!ptr_at_end_s) begin
              ptr_r <= ptr_r + PTR_ONE;
            end
            if (load_last || ptr_at_end_s) begin
              state_r      <= DONE;
              load_ready_r <= 1'b0;
              load_done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r       <= IDLE;
          load_done_r   <= 1'b0;
          load_ready_r  <= 1'b0;
          instruction_r <= NOP_WORD;
          inst_valid_r  <= 1'b0;
          addr_fault_r  <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          load_ready_r  <= 1'b0;
          load_done_r   <= 1'b0;
          instruction_r <= NOP_WORD;
          inst_valid_r  <= 1'b0;
          addr_fault_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Instruction = instruction_r;
  assign InstValid   = inst_valid_r;
  assign AddrFault   = addr_fault_r;
  assign load_ready  = load_ready_r;
  assign load_done   = load_done_r;
  assign load_count  = count_r;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable: directed scenarios plus randomized
// loads and fetches checked against an array-based reference model.
module tb_inst_mem_loadable;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h00000000;

  logic          clk;
  logic          reset;
  logic [31:0]   Address;
  logic          Stall;
  logic [DW-1:0] Instruction;
  logic          InstValid;
  logic          AddrFault;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic [AW:0]   load_count;

  inst_mem_loadable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Stall(Stall),
    .Instruction(Instruction), .InstValid(InstValid), .AddrFault(AddrFault),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image plus expected fetch outputs.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_inst;
  logic        exp_valid;
  logic        exp_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag);
    check({tag, ".inst"},  Instruction,     exp_inst);
    check({tag, ".valid"}, 32'(InstValid),  32'(exp_valid));
    check({tag, ".fault"}, 32'(AddrFault),  32'(exp_fault));
  endtask

  // One IDLE cycle with the given address/stall; model follows the fetch rules.
  task automatic idle_cycle(input logic [31:0] addr, input logic stall, input string tag);
    Address = addr;
    Stall   = stall;
    step();
    if (!stall) begin
      if ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)) begin
        exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b1;
      end else begin
        exp_inst = model_mem[addr / 4]; exp_valid = 1'b1; exp_fault = 1'b0;
      end
    end
    check_fetch(tag);
  endtask

  task automatic expect_load_state(input string tag);
    check({tag, ".inst"},  Instruction,    NOP);
    check({tag, ".valid"}, 32'(InstValid), 32'h0);
    check({tag, ".fault"}, 32'(AddrFault), 32'h0);
  endtask

  logic [31:0] prog [3];
  logic [31:0] addr;
  logic [31:0] word;
  int n, accepted;

  initial begin
    prog[0] = 32'h3c011001; prog[1] = 32'h34240000; prog[2] = 32'h24050000;
    reset = 1'b1; Address = 32'h0; Stall = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;

    // Reset state
    step(); step();
    reset = 1'b0;
    check_fetch("reset");
    check("reset.load_ready", 32'(load_ready), 32'h0);
    check("reset.load_done",  32'(load_done),  32'h0);
    check("reset.load_count", 32'(load_count), 32'h0);

    // Three-word program load with load_last on the third word
    load_start = 1'b1; step(); load_start = 1'b0;
    check("ld3.ready", 32'(load_ready), 32'h1);
    check("ld3.count0", 32'(load_count), 32'h0);
    expect_load_state("ld3.start");
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
      step();
      model_mem[i] = prog[i];
      check("ld3.count", 32'(load_count), 32'(i + 1));
      check("ld3.done",  32'(load_done),  (i == 2) ? 32'h1 : 32'h0);
      check("ld3.ready_during", 32'(load_ready), (i == 2) ? 32'h0 : 32'h1);
      expect_load_state("ld3.word");
    end
    load_valid = 1'b0; load_last = 1'b0;
    step();
    check("ld3.done_pulse_end", 32'(load_done), 32'h0);
    check("ld3.count_hold", 32'(load_count), 32'h3);
    exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
    idle_cycle(32'h4, 1'b0, "fetch4");
    check("fetch4.word", Instruction, 32'h34240000);

    // Stall holds the fetch outputs while Address changes
    idle_cycle(32'h8, 1'b0, "fetch8");
    for (int i = 0; i < 3; i++) begin
      idle_cycle(32'h0, 1'b1, "stall");
      check("stall.word", Instruction, 32'h24050000);
    end

    // Misaligned and out-of-range faults
    idle_cycle(32'h6, 1'b0, "fault6");
    idle_cycle(32'h0, 1'b0, "good0");
    idle_cycle(32'h400, 1'b0, "fault400");
    idle_cycle(32'h80000000, 1'b0, "fault_msb");
    idle_cycle(32'h3fc, 1'b0, "top_word_unloaded");

    // load_start beats Stall; then a full 256-word load without load_last
    Stall = 1'b1; load_start = 1'b1; step(); load_start = 1'b0; Stall = 1'b0;
    check("ldstall.ready", 32'(load_ready), 32'h1);
    expect_load_state("ldstall");
    for (int i = 0; i < DEPTH; i++) begin
      word = $urandom;
      load_valid = 1'b1; load_data = word; load_last = 1'b0;
      load_start = (i == 100);
      step();
      model_mem[i] = word;
      check("ld256.count", 32'(load_count), 32'(i + 1));
      check("ld256.done",  32'(load_done), (i == DEPTH - 1) ? 32'h1 : 32'h0);
    end
    load_start = 1'b0;
    check("ld256.ready_end", 32'(load_ready), 32'h0);
    load_data = ~model_mem[0];
    step();
    load_valid = 1'b0;
    check("ld256.done_clear", 32'(load_done), 32'h0);
    check("ld256.count_hold", 32'(load_count), 32'd256);
    exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
    idle_cycle(32'h0, 1'b0, "ld256.idx0");
    idle_cycle(32'h3fc, 1'b0, "ld256.idx255");
    check("ld256.count_idle", 32'(load_count), 32'd256);

    // Reset aborts a load after two of four words
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word = $urandom;
      load_valid = 1'b1; load_data = word;
      step();
      model_mem[i] = word;
    end
    reset = 1'b1; load_data = ~model_mem[2]; load_start = 1'b1;
    step();
    reset = 1'b0; load_valid = 1'b0; load_start = 1'b0;
    exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
    check_fetch("abort");
    check("abort.ready", 32'(load_ready), 32'h0);
    check("abort.done",  32'(load_done),  32'h0);
    check("abort.count", 32'(load_count), 32'h0);
    idle_cycle(32'h4, 1'b0, "abort.word1");
    check("abort.done_later", 32'(load_done), 32'h0);
    idle_cycle(32'h8, 1'b0, "abort.word2_prior");

    // Randomized short loads with gaps on load_valid
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 20);
      accepted = 0;
      load_start = 1'b1; step(); load_start = 1'b0;
      while (accepted < n) begin
        load_valid = 1'($urandom_range(0, 1));
        word = $urandom;
        load_data = word;
        load_last = (accepted == n - 1);
        step();
        if (load_valid) begin
          model_mem[accepted] = word;
          accepted++;
        end
        check("rld.count", 32'(load_count), 32'(accepted));
        check("rld.done", 32'(load_done), (accepted == n) ? 32'h1 : 32'h0);
        expect_load_state("rld");
      end
      load_valid = 1'b0; load_last = 1'b0;
      step();
      exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
      check_fetch("rld.exit");
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 3))
          0, 1: addr = 32'($urandom_range(0, 24)) * 32'd4;
          2:    addr = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
          default: begin
            addr = $urandom;
            if (addr < 32'h400) addr = addr + 32'h400;
          end
        endcase
        idle_cycle(addr, ($urandom_range(0, 3) == 0), "rfetch");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
